// File: rtl/imm_operand_encoder_pkg.sv
// Shared types and helpers for the operand2 immediate encoder.
// Provides the FSM state type, the shift_operand layout and a rotate-left helper.
package arm_imm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    localparam int ROT_STEPS = 16;

    typedef struct packed {
        logic [3:0] rot;
        logic [7:0] imm8;
    } shift_operand_imm_t;

    // The upper half of the doubled word shifted left is the left rotation.
    function automatic logic [31:0] rol32(input logic [31:0] w, input logic [4:0] amt);
        logic [63:0] d;
        d = {w, w} << amt;
        return d[63:32];
    endfunction

endpackage

// File: rtl/imm_operand_encoder_if.sv
// Request/result handshake bundle for the immediate encoder.
// The encoder sits on the slave side; the requester uses the master side.
interface imm_operand_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_operand;
    logic        out_encodable;
    logic        out_inverted;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_operand, out_encodable, out_inverted
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_operand, out_encodable, out_inverted
    );

endinterface

// File: rtl/imm_operand_encoder_rot_imm_checker.sv
// Tests one rotation against a word and its complement.
// A rotation fits when rotating the word back left leaves only the low byte populated.
module rot_imm_checker
    import arm_imm_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic [3:0]  i_rot,
    output logic        o_hit,
    output logic        o_hit_inv,
    output logic [7:0]  o_imm8,
    output logic [7:0]  o_imm8_inv
);

    logic [31:0] w_t;
    logic [31:0] w_t_inv;

    assign w_t        = rol32(i_value, {i_rot, 1'b0});
    assign w_t_inv    = rol32(~i_value, {i_rot, 1'b0});
    assign o_hit      = (w_t[31:8] == 24'd0);
    assign o_hit_inv  = (w_t_inv[31:8] == 24'd0);
    assign o_imm8     = w_t[7:0];
    assign o_imm8_inv = w_t_inv[7:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Iterative search for a {rotate_imm, immed_8} encoding of a 32-bit constant,
// testing CHECKS_PER_CYCLE rotations per cycle, with optional MVN (inverted) form.
module imm_operand_encoder
    import arm_imm_pkg::*;
#(
    parameter int CHECKS_PER_CYCLE = 1,
    parameter bit ALLOW_INV        = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    imm_operand_encoder_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SEARCH = SEARCH;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]         r_state;
    logic [31:0]        r_value;
    logic [3:0]         r_rot_idx;
    logic               r_inv_hit;
    shift_operand_imm_t r_inv_operand;
    logic [11:0]        r_operand;
    logic               r_encodable;
    logic               r_inverted;
    logic               r_out_valid;

    logic [3:0] w_rot      [CHECKS_PER_CYCLE];
    logic       w_hit      [CHECKS_PER_CYCLE];
    logic       w_hit_inv  [CHECKS_PER_CYCLE];
    logic [7:0] w_imm8     [CHECKS_PER_CYCLE];
    logic [7:0] w_imm8_inv [CHECKS_PER_CYCLE];

    logic               w_plain_found;
    shift_operand_imm_t w_plain_op;
    logic               w_inv_found;
    shift_operand_imm_t w_inv_op;
    logic               w_last;

    for (genvar g = 0; g < CHECKS_PER_CYCLE; g++) begin : g_lane
        assign w_rot[g] = r_rot_idx + 4'(g);

        rot_imm_checker u_chk (
            .i_value    (r_value),
            .i_rot      (w_rot[g]),
            .o_hit      (w_hit[g]),
            .o_hit_inv  (w_hit_inv[g]),
            .o_imm8     (w_imm8[g]),
            .o_imm8_inv (w_imm8_inv[g])
        );
    end

    // Walk lanes from highest to lowest so the smallest rotation is the last one written.
    always_comb begin
        w_plain_found = 1'b0;
        w_plain_op    = '0;
        w_inv_found   = 1'b0;
        w_inv_op      = '0;
        for (int j = CHECKS_PER_CYCLE - 1; j >= 0; j--) begin
            if (w_hit[j]) begin
                w_plain_found = 1'b1;
                w_plain_op    = {w_rot[j], w_imm8[j]};
            end
            if (ALLOW_INV && w_hit_inv[j]) begin
                w_inv_found = 1'b1;
                w_inv_op    = {w_rot[j], w_imm8_inv[j]};
            end
        end
    end

    assign w_last = (({1'b0, r_rot_idx} + 5'(CHECKS_PER_CYCLE)) == 5'(ROT_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_value       <= '0;
            r_rot_idx     <= '0;
            r_inv_hit     <= 1'b0;
            r_inv_operand <= '0;
            r_operand     <= '0;
            r_encodable   <= 1'b0;
            r_inverted    <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_value   <= bus.in_value;
                        r_inv_hit <= 1'b0;
                        r_rot_idx <= '0;
                        r_state   <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (w_plain_found) begin
                        r_operand   <= w_plain_op;
                        r_encodable <= 1'b1;
                        r_inverted  <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        if (w_inv_found && !r_inv_hit) begin
                            r_inv_hit     <= 1'b1;
                            r_inv_operand <= w_inv_op;
                        end
                        // An inverted hit from this very cycle still counts on the last group.
                        if (w_last) begin
                            if (r_inv_hit) begin
                                r_operand   <= r_inv_operand;
                                r_encodable <= 1'b1;
                                r_inverted  <= 1'b1;
                            end else if (w_inv_found) begin
                                r_operand   <= w_inv_op;
                                r_encodable <= 1'b1;
                                r_inverted  <= 1'b1;
                            end else begin
                                r_operand   <= '0;
                                r_encodable <= 1'b0;
                                r_inverted  <= 1'b0;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            r_rot_idx <= r_rot_idx + 4'(CHECKS_PER_CYCLE);
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == ST_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_operand   = r_operand;
    assign bus.out_encodable = r_encodable;
    assign bus.out_inverted  = r_inverted;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Runs three encoder configurations in lockstep against a brute-force decoder-inverse model.
// Instance 0: K=1 with MVN, instance 1: K=16 with MVN, instance 2: K=4 without MVN.
module tb_imm_operand_encoder;

    logic clk;
    logic rst;

    logic        iv;
    logic [31:0] ival;
    logic        ordy;

    logic        ov   [3];
    logic        irdy [3];
    logic [11:0] op   [3];
    logic        enc  [3];
    logic        inv  [3];

    int kOf   [3] = '{1, 16, 4};
    bit invOf [3] = '{1'b1, 1'b1, 1'b0};

    int checkCount = 0;
    int passCount  = 0;

    imm_operand_encoder_if bus0 ();
    imm_operand_encoder_if bus1 ();
    imm_operand_encoder_if bus2 ();

    assign bus0.in_valid = iv;  assign bus0.in_value = ival;  assign bus0.out_ready = ordy;
    assign bus1.in_valid = iv;  assign bus1.in_value = ival;  assign bus1.out_ready = ordy;
    assign bus2.in_valid = iv;  assign bus2.in_value = ival;  assign bus2.out_ready = ordy;

    assign ov[0] = bus0.out_valid;  assign irdy[0] = bus0.in_ready;  assign op[0] = bus0.out_operand;
    assign enc[0] = bus0.out_encodable;  assign inv[0] = bus0.out_inverted;
    assign ov[1] = bus1.out_valid;  assign irdy[1] = bus1.in_ready;  assign op[1] = bus1.out_operand;
    assign enc[1] = bus1.out_encodable;  assign inv[1] = bus1.out_inverted;
    assign ov[2] = bus2.out_valid;  assign irdy[2] = bus2.in_ready;  assign op[2] = bus2.out_operand;
    assign enc[2] = bus2.out_encodable;  assign inv[2] = bus2.out_inverted;

    imm_operand_encoder #(.CHECKS_PER_CYCLE(1), .ALLOW_INV(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    imm_operand_encoder #(.CHECKS_PER_CYCLE(16), .ALLOW_INV(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    imm_operand_encoder #(.CHECKS_PER_CYCLE(4), .ALLOW_INV(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] ror32(input logic [7:0] imm, input int r);
        logic [63:0] x;
        x = {24'h0, imm, 24'h0, imm} >> (2 * r);
        return x[31:0];
    endfunction

    // Inverse of the decoder by exhaustion: smallest rotation first, plain form before MVN form.
    function automatic void refEncode(input logic [31:0] v, input bit allowInv, input int k,
                                      output logic [11:0] eop, output logic eenc,
                                      output logic einv, output int elat);
        eop = '0; eenc = 1'b0; einv = 1'b0; elat = 16 / k + 1;
        for (int r = 0; r < 16; r++)
            for (int imm = 0; imm < 256; imm++)
                if (ror32(8'(imm), r) == v) begin
                    eop = {4'(r), 8'(imm)}; eenc = 1'b1; elat = (r + k) / k + 1;
                    return;
                end
        if (allowInv)
            for (int r = 0; r < 16; r++)
                for (int imm = 0; imm < 256; imm++)
                    if (ror32(8'(imm), r) == ~v) begin
                        eop = {4'(r), 8'(imm)}; eenc = 1'b1; einv = 1'b1;
                        return;
                    end
    endfunction

    task automatic applyStimulus(input logic [31:0] value, input int holdCycles);
        int lat [3];
        int cycles;
        logic [11:0] eop;
        logic eenc, einv;
        int elat;
        logic [31:0] decoded;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("u%0d in_ready before %08h", i, value), 32'(irdy[i]), 32'd1);
        @(negedge clk);
        iv = 1'b1; ival = value;
        @(posedge clk); #1;
        iv = 1'b0; ival = $urandom;
        lat = '{0, 0, 0};
        cycles = 0;
        while (!(lat[0] != 0 && lat[1] != 0 && lat[2] != 0) && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            for (int i = 0; i < 3; i++) if (ov[i] && lat[i] == 0) lat[i] = cycles;
        end
        for (int i = 0; i < 3; i++) begin
            refEncode(value, invOf[i], kOf[i], eop, eenc, einv, elat);
            checkOutput($sformatf("u%0d operand %08h", i, value), 32'(op[i]), 32'(eop));
            checkOutput($sformatf("u%0d encodable %08h", i, value), 32'(enc[i]), 32'(eenc));
            checkOutput($sformatf("u%0d inverted %08h", i, value), 32'(inv[i]), 32'(einv));
            checkOutput($sformatf("u%0d latency %08h", i, value), 32'(lat[i]), 32'(elat));
            if (eenc) begin
                decoded = ror32(op[i][7:0], int'(op[i][11:8]));
                checkOutput($sformatf("u%0d redecode %08h", i, value), decoded, einv ? ~value : value);
            end
        end
        if (holdCycles > 0) begin
            eop = op[0];
            iv = 1'b1; ival = 32'h000000AA;
            for (int c = 0; c < holdCycles; c++) begin
                @(posedge clk); #1;
                checkOutput($sformatf("hold%0d out_valid", c), 32'(ov[0]), 32'd1);
                checkOutput($sformatf("hold%0d operand", c), 32'(op[0]), 32'(eop));
                checkOutput($sformatf("hold%0d in_ready", c), 32'(irdy[0]), 32'd0);
            end
            @(negedge clk);
            iv = 1'b0;
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d out_valid after take", i), 32'(ov[i]), 32'd0);
            checkOutput($sformatf("u%0d in_ready after take", i), 32'(irdy[i]), 32'd1);
        end
    endtask

    logic [31:0] directed [8] = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h00000000,
                                  32'h000003FC, 32'hFFFFFF00, 32'h00000101, 32'hFFFFFFFF};

    initial begin
        logic [31:0] v;
        iv = 1'b0; ival = '0; ordy = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d reset out_valid", i), 32'(ov[i]), 32'd0);
            checkOutput($sformatf("u%0d reset in_ready", i), 32'(irdy[i]), 32'd1);
            checkOutput($sformatf("u%0d reset operand", i), 32'(op[i]), 32'd0);
            checkOutput($sformatf("u%0d reset flags", i), {30'd0, enc[i], inv[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) applyStimulus(directed[t], 0);

        applyStimulus(32'h00000F00, 5);

        // Abort a long K=1 search partway through with an asynchronous reset pulse.
        @(negedge clk);
        iv = 1'b1; ival = 32'h000003FC;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d midreset out_valid", i), 32'(ov[i]), 32'd0);
            checkOutput($sformatf("u%0d midreset in_ready", i), 32'(irdy[i]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h000003FC, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: v = ror32(8'($urandom), int'($urandom_range(0, 15)));
                1: v = ~ror32(8'($urandom), int'($urandom_range(0, 15)));
                default: v = $urandom;
            endcase
            applyStimulus(v, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
